// File: rtl/bcd_stopwatch_cnt_pkg.sv
// Shared BCD digit type, digit limits and the preset clamp used by the stopwatch core.
package bcd_stopwatch_cnt_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  // Preset nibbles above 9 are forced to 9 so no illegal BCD can be loaded.
  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_stopwatch_cnt_digit.sv
// One BCD digit: clear > load > step, wrapping 9->0 up and 0->9 down.
module bcd_stopwatch_cnt_digit
  import bcd_stopwatch_cnt_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic dir,
  input  logic clr,
  input  logic load,
  input  bcd_t ld_val,
  output bcd_t val,
  output bcd_t nxt,
  output logic at_max,
  output logic at_min
);

  bcd_t val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = BCD_MIN;
    end else if (load) begin
      val_d = bcd_clamp(ld_val);
    end else if (en) begin
      if (dir) val_d = (val_q == BCD_MIN) ? BCD_MAX : val_q - 4'd1;
      else     val_d = (val_q == BCD_MAX) ? BCD_MIN : val_q + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) val_q <= BCD_MIN;
    else     val_q <= val_d;
  end

  assign val    = val_q;
  assign nxt    = val_d;
  assign at_max = (val_q == BCD_MAX);
  assign at_min = (val_q == BCD_MIN);

endmodule

// File: rtl/bcd_stopwatch_cnt.sv
// N-digit BCD stopwatch/countdown: prescaler, run/hold/done/ovf control and digit carry chain.
module bcd_stopwatch_cnt
  import bcd_stopwatch_cnt_pkg::*;
#(
  parameter int unsigned NDIG     = 4,
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BTN_SS,
  input  logic              CLR,
  input  logic              LOAD,
  input  logic [4*NDIG-1:0] LOAD_VAL,
  input  logic              DIR,
  input  logic              LAP,
  output logic [4*NDIG-1:0] VAL,
  output logic              RUN,
  output logic              HOLD,
  output logic              OVF,
  output logic              DONE
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [4*NDIG-1:0] CNT_ONE = (4*NDIG)'(1);

  logic [PW-1:0]     presc_q, presc_d;
  logic              run_q, run_d, hold_q, hold_d, done_q, done_d, ovf_q, ovf_d;
  logic [4*NDIG-1:0] snap_q, snap_d, val_q, val_d;
  logic [4*NDIG-1:0] count, count_nxt;
  logic [NDIG-1:0]   at_max, at_min, en;
  logic [NDIG:0]     carry, borrow;
  logic              tick, step_ok, term, all_max, all_min;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < NDIG; i++) begin : g_digit
    assign carry[i+1]  = carry[i] & at_max[i];
    assign borrow[i+1] = borrow[i] & at_min[i];
    assign en[i]       = step_ok & (DIR ? borrow[i] : carry[i]);

    bcd_stopwatch_cnt_digit u_digit (
      .CLK    (CLK),
      .RST    (RST),
      .en     (en[i]),
      .dir    (DIR),
      .clr    (CLR),
      .load   (LOAD),
      .ld_val (LOAD_VAL[4*i +: 4]),
      .val    (count[4*i +: 4]),
      .nxt    (count_nxt[4*i +: 4]),
      .at_max (at_max[i]),
      .at_min (at_min[i])
    );
  end

  assign all_max = carry[NDIG];
  assign all_min = borrow[NDIG];
  assign tick    = run_q & (presc_q == PRESC_MAX);
  // A down step from zero would borrow to all nines; suppress it and stop instead.
  assign step_ok = tick & ~(DIR & all_min);
  assign term    = tick & DIR & (all_min | (count == CNT_ONE));

  always_comb begin
    presc_d = presc_q;
    run_d   = run_q;
    done_d  = done_q;
    ovf_d   = 1'b0;
    hold_d  = hold_q;
    snap_d  = snap_q;
    val_d   = hold_q ? snap_q : count;
    if (CLR) begin
      presc_d = '0;
      run_d   = 1'b0;
      done_d  = 1'b0;
      hold_d  = 1'b0;
      val_d   = '0;
    end else begin
      if (LOAD) begin
        presc_d = '0;
        run_d   = 1'b0;
        done_d  = 1'b0;
      end else begin
        if (tick)       presc_d = '0;
        else if (run_q) presc_d = presc_q + 1'b1;
        ovf_d = tick & ~DIR & all_max;
        if (term) begin
          run_d  = 1'b0;
          done_d = 1'b1;
        end
        if (BTN_SS) begin
          if (run_q) begin
            run_d = 1'b0;
          end else if (!(DIR && all_min)) begin
            run_d  = 1'b1;
            done_d = 1'b0;
          end
        end
      end
      if (LAP) begin
        hold_d = ~hold_q;
        if (!hold_q) snap_d = count_nxt;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q <= '0;
      run_q   <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      snap_q  <= '0;
      val_q   <= '0;
    end else begin
      presc_q <= presc_d;
      run_q   <= run_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      snap_q  <= snap_d;
      val_q   <= val_d;
    end
  end

  assign VAL  = val_q;
  assign RUN  = run_q;
  assign HOLD = hold_q;
  assign OVF  = ovf_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_bcd_stopwatch_cnt.sv
// Stopwatch bench: directed scenarios plus random traffic against an integer-valued stopwatch model.
module tb_bcd_stopwatch_cnt;

  localparam int NDIG = 4;
  localparam int TD   = 4;
  localparam int MAXV = 9999;

  logic        CLK = 1'b0;
  logic        RST, BTN_SS, CLR, LOAD, DIR, LAP;
  logic [15:0] LOAD_VAL;
  logic [15:0] VAL;
  logic        RUN, HOLD, OVF, DONE;

  always #5 CLK = ~CLK;

  bcd_stopwatch_cnt #(.NDIG(NDIG), .TICK_DIV(TD)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .BTN_SS   (BTN_SS),
    .CLR      (CLR),
    .LOAD     (LOAD),
    .LOAD_VAL (LOAD_VAL),
    .DIR      (DIR),
    .LAP      (LAP),
    .VAL      (VAL),
    .RUN      (RUN),
    .HOLD     (HOLD),
    .OVF      (OVF),
    .DONE     (DONE)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: the count is a plain integer 0..9999.
  int m_cnt, m_presc, m_snap, m_val;
  bit m_run, m_hold, m_done, m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [15:0] b);
    int v, w;
    logic [3:0] d;
    v = 0;
    w = 1;
    for (int i = 0; i < NDIG; i++) begin
      d = b[4*i +: 4];
      v += ((d > 4'd9) ? 9 : int'(d)) * w;
      w *= 10;
    end
    return v;
  endfunction

  task automatic model_step();
    int  n_cnt;
    bit  tick;
    if (RST) begin
      m_cnt = 0; m_presc = 0; m_snap = 0; m_val = 0;
      m_run = 0; m_hold = 0; m_done = 0; m_ovf = 0;
      return;
    end
    tick  = m_run && (m_presc == TD - 1);
    n_cnt = m_cnt;
    m_val = m_hold ? m_snap : m_cnt;
    m_ovf = 0;
    if (CLR) begin
      m_cnt = 0; m_presc = 0; m_run = 0; m_done = 0; m_hold = 0; m_val = 0;
      return;
    end
    if (LOAD) begin
      n_cnt = clamp_val(LOAD_VAL);
      m_presc = 0; m_run = 0; m_done = 0;
    end else begin
      bit old_run;
      old_run = m_run;
      if (tick) begin
        m_presc = 0;
        if (!DIR) begin
          m_ovf = (m_cnt == MAXV);
          n_cnt = (m_cnt + 1) % (MAXV + 1);
        end else if (m_cnt <= 1) begin
          n_cnt = 0; m_run = 0; m_done = 1;
        end else begin
          n_cnt = m_cnt - 1;
        end
      end else if (m_run) begin
        m_presc++;
      end
      if (BTN_SS) begin
        if (old_run) m_run = 0;
        else if (!(DIR && m_cnt == 0)) begin
          m_run = 1; m_done = 0;
        end
      end
    end
    if (LAP) begin
      if (!m_hold) m_snap = n_cnt;
      m_hold = !m_hold;
    end
    m_cnt = n_cnt;
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check("VAL",  32'(VAL),  32'(to_bcd(m_val)));
    check("RUN",  32'(RUN),  32'(m_run));
    check("HOLD", 32'(HOLD), 32'(m_hold));
    check("OVF",  32'(OVF),  32'(m_ovf));
    check("DONE", 32'(DONE), 32'(m_done));
  endtask

  task automatic drive(input bit btn, input bit clr, input bit load, input bit lap);
    BTN_SS = btn; CLR = clr; LOAD = load; LAP = lap;
    cyc();
    BTN_SS = 0; CLR = 0; LOAD = 0; LAP = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int ovf_seen;
    RST = 1; BTN_SS = 0; CLR = 0; LOAD = 0; DIR = 0; LAP = 0; LOAD_VAL = '0;
    @(negedge CLK);
    idle(2);
    check("reset_val", 32'(VAL), 32'h0);
    RST = 0;

    // 1: first step TICK_DIV edges after start, VAL one cycle later; stop freezes.
    drive(1, 0, 0, 0);
    idle(5);
    check("t1_first", 32'(VAL), 32'h0001);
    idle(4);
    check("t1_second", 32'(VAL), 32'h0002);
    drive(1, 0, 0, 0);
    idle(8);
    check("t1_frozen", 32'(VAL), 32'h0002);

    // 2: up wrap with single-cycle overflow.
    LOAD_VAL = 16'h9998; DIR = 0;
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);
    ovf_seen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (OVF) ovf_seen++;
    end
    check("t2_ovf_once", 32'(ovf_seen), 32'd1);
    check("t2_run", 32'(RUN), 32'd1);

    // 3: countdown to zero, then start is ignored.
    LOAD_VAL = 16'h0002; DIR = 1;
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);
    idle(12);
    check("t3_done", 32'(DONE), 32'd1);
    drive(1, 0, 0, 0);
    idle(2);
    check("t3_ignored", 32'(RUN), 32'd0);

    // 4: borrow chain and preset clamp.
    LOAD_VAL = 16'h0100;
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);
    idle(5);
    check("t4_borrow", 32'(VAL), 32'h0099);
    LOAD_VAL = 16'hF9A3;
    drive(0, 0, 1, 0);
    idle(1);
    check("t4_clamp", 32'(VAL), 32'h9993);

    // 5: lap freezes the display while the count advances.
    LOAD_VAL = 16'h0012; DIR = 0;
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 1);
    idle(12);
    check("t5_held", 32'(VAL), 32'h0012);
    drive(0, 0, 0, 1);
    idle(1);
    check("t5_release", 32'(VAL), 32'h0015);

    // 6: stop on the tick edge, then simultaneous CLR/LOAD/LAP.
    for (int i = 0; i < 8 && !(m_run && m_presc == TD - 1); i++) cyc();
    check("t6_aligned", 32'(m_presc), 32'(TD - 1));
    drive(1, 0, 0, 0);
    check("t6_stopped", 32'(RUN), 32'd0);
    LOAD_VAL = 16'h4321;
    drive(0, 1, 1, 1);
    check("t6_clr_val", 32'(VAL), 32'h0);
    check("t6_clr_hold", 32'(HOLD), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      RST    = ($urandom_range(999) == 0);
      BTN_SS = ($urandom_range(15) == 0);
      CLR    = ($urandom_range(199) == 0);
      LOAD   = ($urandom_range(63) == 0);
      LAP    = ($urandom_range(31) == 0);
      if ($urandom_range(63) == 0) DIR = ~DIR;
      case ($urandom_range(3))
        0:       LOAD_VAL = 16'h9998;
        1:       LOAD_VAL = 16'h0002;
        default: LOAD_VAL = 16'($urandom);
      endcase
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
